// File: rtl/sy_ppl_fp_rat_if.sv
// Rename-stage bus for the FP register alias table: decode side, free list,
// dispatch side, writeback and commit, grouped under master/slave modports.
interface sy_ppl_fp_rat_if #(
    parameter int PHY_REG_NUM = 64
);
    localparam int PHY_REG_WTH = $clog2(PHY_REG_NUM);

    logic                   flush_i;
    logic                   ren_vld_i;
    logic                   ren_rdy_o;
    logic [4:0]             rs1_idx_i;
    logic [4:0]             rs2_idx_i;
    logic [4:0]             rs3_idx_i;
    logic                   rdst_en_i;
    logic [4:0]             rdst_idx_i;
    logic                   fl_stall_i;
    logic [PHY_REG_WTH-1:0] fl_phy_i;
    logic                   fl_alloc_o;
    logic                   dsp_vld_o;
    logic                   dsp_rdy_i;
    logic [PHY_REG_WTH-1:0] dsp_phy_rs1_o;
    logic [PHY_REG_WTH-1:0] dsp_phy_rs2_o;
    logic [PHY_REG_WTH-1:0] dsp_phy_rs3_o;
    logic                   dsp_rs1_rdy_o;
    logic                   dsp_rs2_rdy_o;
    logic                   dsp_rs3_rdy_o;
    logic                   dsp_rdst_en_o;
    logic [PHY_REG_WTH-1:0] dsp_phy_rdst_o;
    logic [PHY_REG_WTH-1:0] dsp_old_phy_rdst_o;
    logic                   wb_en_i;
    logic [PHY_REG_WTH-1:0] wb_phy_i;
    logic                   cmt_en_i;
    logic [4:0]             cmt_arc_idx_i;
    logic [PHY_REG_WTH-1:0] cmt_phy_i;

    modport master (
        output flush_i, ren_vld_i, rs1_idx_i, rs2_idx_i, rs3_idx_i,
               rdst_en_i, rdst_idx_i, fl_stall_i, fl_phy_i, dsp_rdy_i,
               wb_en_i, wb_phy_i, cmt_en_i, cmt_arc_idx_i, cmt_phy_i,
        input  ren_rdy_o, fl_alloc_o, dsp_vld_o, dsp_phy_rs1_o, dsp_phy_rs2_o,
               dsp_phy_rs3_o, dsp_rs1_rdy_o, dsp_rs2_rdy_o, dsp_rs3_rdy_o,
               dsp_rdst_en_o, dsp_phy_rdst_o, dsp_old_phy_rdst_o
    );

    modport slave (
        input  flush_i, ren_vld_i, rs1_idx_i, rs2_idx_i, rs3_idx_i,
               rdst_en_i, rdst_idx_i, fl_stall_i, fl_phy_i, dsp_rdy_i,
               wb_en_i, wb_phy_i, cmt_en_i, cmt_arc_idx_i, cmt_phy_i,
        output ren_rdy_o, fl_alloc_o, dsp_vld_o, dsp_phy_rs1_o, dsp_phy_rs2_o,
               dsp_phy_rs3_o, dsp_rs1_rdy_o, dsp_rs2_rdy_o, dsp_rs3_rdy_o,
               dsp_rdst_en_o, dsp_phy_rdst_o, dsp_old_phy_rdst_o
    );
endinterface

// File: rtl/sy_ppl_fp_rat.sv
// FP register alias table: speculative/committed maps, per-physical ready bits
// and a one-entry registered output toward dispatch.
module sy_ppl_fp_rat #(
    parameter int PHY_REG_NUM = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sy_ppl_fp_rat_if.slave rat
);
    localparam int PHY_REG_WTH = $clog2(PHY_REG_NUM);

    logic [PHY_REG_WTH-1:0] r_spec_map [32];
    logic [PHY_REG_WTH-1:0] r_arch_map [32];
    logic [PHY_REG_NUM-1:0] r_rdy;

    logic                   r_dsp_vld;
    logic [PHY_REG_WTH-1:0] r_dsp_phy_rs1;
    logic [PHY_REG_WTH-1:0] r_dsp_phy_rs2;
    logic [PHY_REG_WTH-1:0] r_dsp_phy_rs3;
    logic                   r_dsp_rs1_rdy;
    logic                   r_dsp_rs2_rdy;
    logic                   r_dsp_rs3_rdy;
    logic                   r_dsp_rdst_en;
    logic [PHY_REG_WTH-1:0] r_dsp_phy_rdst;
    logic [PHY_REG_WTH-1:0] r_dsp_old_phy_rdst;

    logic                   w_ren_rdy;
    logic                   w_fire;
    logic                   w_alloc;
    logic [PHY_REG_WTH-1:0] w_phy_rs1;
    logic [PHY_REG_WTH-1:0] w_phy_rs2;
    logic [PHY_REG_WTH-1:0] w_phy_rs3;
    logic                   w_rs1_rdy;
    logic                   w_rs2_rdy;
    logic                   w_rs3_rdy;
    logic [PHY_REG_WTH-1:0] w_old_phy;

    assign w_ren_rdy = !rst_i && !rat.flush_i && (!r_dsp_vld || rat.dsp_rdy_i)
                       && !(rat.rdst_en_i && rat.fl_stall_i);
    assign w_fire    = rat.ren_vld_i && w_ren_rdy;
    assign w_alloc   = w_fire && rat.rdst_en_i;

    // Lookup uses the pre-update map, so a source equal to rd sees the old mapping.
    assign w_phy_rs1 = r_spec_map[rat.rs1_idx_i];
    assign w_phy_rs2 = r_spec_map[rat.rs2_idx_i];
    assign w_phy_rs3 = r_spec_map[rat.rs3_idx_i];
    assign w_old_phy = r_spec_map[rat.rdst_idx_i];
    assign w_rs1_rdy = r_rdy[w_phy_rs1] || (rat.wb_en_i && rat.wb_phy_i == w_phy_rs1);
    assign w_rs2_rdy = r_rdy[w_phy_rs2] || (rat.wb_en_i && rat.wb_phy_i == w_phy_rs2);
    assign w_rs3_rdy = r_rdy[w_phy_rs3] || (rat.wb_en_i && rat.wb_phy_i == w_phy_rs3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) r_arch_map[i] <= PHY_REG_WTH'(i);
        end else if (rat.cmt_en_i) begin
            r_arch_map[rat.cmt_arc_idx_i] <= rat.cmt_phy_i;
        end
    end

    // Flush restores from the committed map with this cycle's commit folded in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) r_spec_map[i] <= PHY_REG_WTH'(i);
        end else if (rat.flush_i) begin
            for (int i = 0; i < 32; i++)
                r_spec_map[i] <= (rat.cmt_en_i && rat.cmt_arc_idx_i == 5'(i)) ?
                                 rat.cmt_phy_i : r_arch_map[i];
        end else if (w_alloc) begin
            r_spec_map[rat.rdst_idx_i] <= rat.fl_phy_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || rat.flush_i) begin
            r_rdy <= '1;
        end else begin
            if (rat.wb_en_i) r_rdy[rat.wb_phy_i] <= 1'b1;
            if (w_alloc)     r_rdy[rat.fl_phy_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dsp_vld          <= 1'b0;
            r_dsp_phy_rs1      <= '0;
            r_dsp_phy_rs2      <= '0;
            r_dsp_phy_rs3      <= '0;
            r_dsp_rs1_rdy      <= 1'b0;
            r_dsp_rs2_rdy      <= 1'b0;
            r_dsp_rs3_rdy      <= 1'b0;
            r_dsp_rdst_en      <= 1'b0;
            r_dsp_phy_rdst     <= '0;
            r_dsp_old_phy_rdst <= '0;
        end else if (rat.flush_i) begin
            r_dsp_vld <= 1'b0;
        end else if (w_fire) begin
            r_dsp_vld          <= 1'b1;
            r_dsp_phy_rs1      <= w_phy_rs1;
            r_dsp_phy_rs2      <= w_phy_rs2;
            r_dsp_phy_rs3      <= w_phy_rs3;
            r_dsp_rs1_rdy      <= w_rs1_rdy;
            r_dsp_rs2_rdy      <= w_rs2_rdy;
            r_dsp_rs3_rdy      <= w_rs3_rdy;
            r_dsp_rdst_en      <= rat.rdst_en_i;
            r_dsp_phy_rdst     <= rat.fl_phy_i;
            r_dsp_old_phy_rdst <= w_old_phy;
        end else begin
            if (r_dsp_vld && rat.dsp_rdy_i) r_dsp_vld <= 1'b0;
            // A held instruction still picks up writebacks for its sources.
            if (r_dsp_vld && rat.wb_en_i) begin
                if (rat.wb_phy_i == r_dsp_phy_rs1) r_dsp_rs1_rdy <= 1'b1;
                if (rat.wb_phy_i == r_dsp_phy_rs2) r_dsp_rs2_rdy <= 1'b1;
                if (rat.wb_phy_i == r_dsp_phy_rs3) r_dsp_rs3_rdy <= 1'b1;
            end
        end
    end

    assign rat.ren_rdy_o          = w_ren_rdy;
    assign rat.fl_alloc_o         = w_alloc;
    assign rat.dsp_vld_o          = r_dsp_vld;
    assign rat.dsp_phy_rs1_o      = r_dsp_phy_rs1;
    assign rat.dsp_phy_rs2_o      = r_dsp_phy_rs2;
    assign rat.dsp_phy_rs3_o      = r_dsp_phy_rs3;
    assign rat.dsp_rs1_rdy_o      = r_dsp_rs1_rdy;
    assign rat.dsp_rs2_rdy_o      = r_dsp_rs2_rdy;
    assign rat.dsp_rs3_rdy_o      = r_dsp_rs3_rdy;
    assign rat.dsp_rdst_en_o      = r_dsp_rdst_en;
    assign rat.dsp_phy_rdst_o     = r_dsp_phy_rdst;
    assign rat.dsp_old_phy_rdst_o = r_dsp_old_phy_rdst;
endmodule
